// File: rtl/out_port_ctrl_pkg.sv
// Shared defaults and handshake state encoding for the CPU output port.
package out_port_ctrl_pkg;

    localparam int unsigned DefaultDataW = 32;
    localparam int unsigned DefaultDepth = 4;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StReq     = 2'd1,
        StRelease = 2'd2
    } hs_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push while full is accepted only alongside a pop.
module sync_fifo
    import out_port_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DefaultDataW,
    parameter int unsigned DEPTH  = DefaultDepth
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          din,
    output logic [DATA_W-1:0]          dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CntW = AW + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   count_q;
    logic              do_push;

    assign full    = (count_q == FullCnt);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    // A full FIFO can still take a word when the head leaves at the same edge.
    assign do_push = push & (~full | pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({do_push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/out_port_ctrl.sv
// CPU output port: holding register, word queue and four-phase valid/ack device handshake.
module out_port_ctrl
    import out_port_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DefaultDataW,
    parameter int unsigned DEPTH  = DefaultDepth
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              OutPortIn,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] outport_data_out,
    output logic              dev_valid,
    output logic [DATA_W-1:0] dev_data,
    input  logic              dev_ack,
    output logic              fifo_full,
    output logic              overflow,
    output logic              busy
);

    hs_state_e                 state_q, state_d;
    logic                      pop;
    logic                      full;
    logic                      empty;
    logic [DATA_W-1:0]         head;
    logic [$clog2(DEPTH):0]    count;
    logic [DATA_W-1:0]         hold_q;
    logic [DATA_W-1:0]         dev_data_q;
    logic                      overflow_q;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .clr   (clr),
        .push  (OutPortIn),
        .pop   (pop),
        .din   (bus_in),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (!empty)  state_d = StReq;
            StReq:     if (dev_ack) state_d = StRelease;
            StRelease: if (!dev_ack) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // dev_valid is exactly "in REQ", so it drops on the ack edge and on clr.
    always_comb begin
        pop       = (state_q == StIdle) && !empty;
        dev_valid = (state_q == StReq);
        busy      = (count != '0) || (state_q != StIdle);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            hold_q     <= '0;
            dev_data_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (OutPortIn) begin
                hold_q <= bus_in;
            end
            if (pop) begin
                dev_data_q <= head;
            end
            if (OutPortIn && full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign outport_data_out = hold_q;
    assign dev_data         = dev_data_q;
    assign overflow         = overflow_q;
    assign fifo_full        = full;

endmodule
